// File: rtl/eq_pkg.sv
// Shared sizing, state encoding and output rounding/saturation for the gain mixer.
// Pure definitions; no timing or flow-control behaviour of its own.
package eq_pkg;

  localparam int NB        = 10;
  localparam int DATA_W    = 24;
  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 14;
  localparam int PROD_W    = DATA_W + GAIN_W;
  localparam int ACC_W     = PROD_W + $clog2(NB);
  localparam int IDX_W     = 4;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h4000;

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (GAIN_FRAC - 1);
  localparam logic signed [ACC_W-1:0] DATA_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] DATA_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic              sat;
    logic [DATA_W-1:0] data;
  } out_t;

  // Round half up at the Q2.14 point, then clip to the sample range.
  function automatic out_t round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shf;
    out_t r;
    shf = (acc + RND_HALF) >>> GAIN_FRAC;
    if (shf > DATA_MAX) begin
      r.sat  = 1'b1;
      r.data = DATA_MAX[DATA_W-1:0];
    end else if (shf < DATA_MIN) begin
      r.sat  = 1'b1;
      r.data = DATA_MIN[DATA_W-1:0];
    end else begin
      r.sat  = 1'b0;
      r.data = shf[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/eq_mac_stage.sv
// Registered signed sample x gain multiplier, one product per enabled cycle.
// Latency 1 cycle; no backpressure, i_clr has priority over i_en.
module eq_mac_stage
  import eq_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [GAIN_W-1:0] i_b,
  output logic signed [PROD_W-1:0] o_prod
);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      o_prod <= '0;
    end else if (i_en) begin
      o_prod <= PROD_W'(i_a) * PROD_W'(i_b);
    end
  end

endmodule

// File: rtl/eq_gain_mixer.sv
// Per-band gain mixer: one shared multiplier, o_valid 12 cycles after an accepted i_en.
// i_en while busy is dropped and flagged by a one-cycle o_overrun pulse.
module eq_gain_mixer
  import eq_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [NB*DATA_W-1:0] i_band_data,
  input  logic                 i_gain_we,
  input  logic [IDX_W-1:0]     i_gain_addr,
  input  logic [GAIN_W-1:0]    i_gain_data,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_valid,
  output logic                 o_sat,
  output logic                 o_busy,
  output logic                 o_overrun
);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic signed [DATA_W-1:0] band_q    [NB];
  logic signed [GAIN_W-1:0] gain_pend [NB];
  logic signed [GAIN_W-1:0] gain_act  [NB];
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic                     accept;
  out_t                     res;

  assign accept = (state == ST_IDLE) && i_en;
  assign res    = round_sat(acc);

  eq_mac_stage u_mac (
    .i_clk  (i_clk),
    .i_clr  (!i_rst_n),
    .i_en   (state == ST_MAC),
    .i_a    (band_q[idx]),
    .i_b    (gain_act[idx]),
    .o_prod (prod)
  );

  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int b = 0; b < NB; b++) begin
        band_q[b] <= i_band_data[b*DATA_W +: DATA_W];
      end
    end
  end

  // Active bank only moves at sample acceptance so one result never mixes gain sets.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NB; b++) begin
        gain_pend[b] <= GAIN_UNITY;
        gain_act[b]  <= GAIN_UNITY;
      end
    end else begin
      if (accept) begin
        for (int b = 0; b < NB; b++) begin
          gain_act[b] <= gain_pend[b];
        end
      end
      if (i_gain_we && (i_gain_addr < IDX_W'(NB))) begin
        gain_pend[i_gain_addr] <= i_gain_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      acc       <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_sat     <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_sat     <= 1'b0;
      o_overrun <= i_en && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (i_en) begin
            acc    <= '0;
            idx    <= '0;
            o_busy <= 1'b1;
            state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          // The product register lags idx by one edge, so the first add waits a cycle.
          if (idx != '0) begin
            acc <= acc + ACC_W'(prod);
          end
          idx <= idx + 1'b1;
          if (idx == IDX_W'(NB - 1)) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          acc   <= acc + ACC_W'(prod);
          state <= ST_OUT;
        end
        ST_OUT: begin
          o_data  <= res.data;
          o_sat   <= res.sat;
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_gain_mixer.sv
// Directed scoreboard bench for eq_gain_mixer: expected results queued at acceptance,
// compared on o_valid together with exact result cycle, busy and overrun behaviour.
module tb_eq_gain_mixer;

  localparam int NB = 10;
  localparam int DW = 24;
  localparam int GW = 16;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_en = 1'b0;
  logic [NB*DW-1:0]  i_band_data = '0;
  logic              i_gain_we = 1'b0;
  logic [3:0]        i_gain_addr = '0;
  logic [GW-1:0]     i_gain_data = '0;
  logic [DW-1:0]     o_data;
  logic              o_valid;
  logic              o_sat;
  logic              o_busy;
  logic              o_overrun;

  eq_gain_mixer dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_band_data (i_band_data),
    .i_gain_we   (i_gain_we),
    .i_gain_addr (i_gain_addr),
    .i_gain_data (i_gain_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_sat       (o_sat),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          sat;
    int unsigned   cyc;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  logic [GW-1:0] gpend [NB];
  logic          have_last = 1'b0;
  int unsigned   last_e = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [NB*DW-1:0] bands);
    longint sum, r;
    logic signed [DW-1:0] v;
    logic signed [GW-1:0] g;
    exp_t e;
    sum = 0;
    for (int b = 0; b < NB; b++) begin
      v = bands[b*DW +: DW];
      g = gpend[b];
      sum += longint'(v) * longint'(g);
    end
    r = (sum + 8192) >>> 14;
    e.sat = 1'b0;
    if (r > 64'sd8388607) begin
      r = 64'sd8388607;
      e.sat = 1'b1;
    end else if (r < -64'sd8388608) begin
      r = -64'sd8388608;
      e.sat = 1'b1;
    end
    e.data = r[DW-1:0];
    e.cyc  = 0;
    return e;
  endfunction

  // Output side of the scoreboard.
  always @(negedge i_clk) begin
    if (o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'(o_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_data", 64'(o_data), 64'(e.data));
        chk("result_sat", 64'(o_sat), 64'(e.sat));
        chk("result_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drive one cycle (called at a negedge), update the model at the edge, check busy/overrun.
  task automatic step(input logic en, input logic we = 1'b0, input logic [3:0] addr = 4'd0,
                      input logic [GW-1:0] gd = '0, input logic rst_n = 1'b1);
    int unsigned pre;
    logic acc_ok, exp_ovr, exp_busy;
    exp_t e;
    i_en        = en;
    i_gain_we   = we;
    i_gain_addr = addr;
    i_gain_data = gd;
    i_rst_n     = rst_n;
    @(posedge i_clk);
    pre = cyc;
    if (!rst_n) begin
      q.delete();
      have_last = 1'b0;
      for (int b = 0; b < NB; b++) gpend[b] = 16'h4000;
      exp_ovr  = 1'b0;
      exp_busy = 1'b0;
    end else begin
      acc_ok  = en && (!have_last || (pre >= last_e + 13));
      exp_ovr = en && !acc_ok;
      if (acc_ok) begin
        e = model(i_band_data);
        e.cyc = pre + 13;
        q.push_back(e);
        last_e    = pre;
        have_last = 1'b1;
      end
      if (we && addr < 4'(NB)) gpend[addr] = gd;
      exp_busy = have_last && ((pre - last_e) <= 11);
    end
    @(negedge i_clk);
    chk("overrun", 64'(o_overrun), 64'(exp_ovr));
    chk("busy", 64'(o_busy), 64'(exp_busy));
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) step(1'b0);
    step(1'b0);
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic set_all(input logic [DW-1:0] v);
    for (int b = 0; b < NB; b++) i_band_data[b*DW +: DW] = v;
  endtask

  initial begin
    for (int b = 0; b < NB; b++) gpend[b] = 16'h4000;
    @(negedge i_clk);
    step(1'b0, 1'b0, 4'd0, '0, 1'b0);
    step(1'b0, 1'b0, 4'd0, '0, 1'b0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_sat", 64'(o_sat), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_overrun", 64'(o_overrun), 64'd0);

    // Unity gains, all bands 1000.
    set_all(24'd1000);
    step(1'b1);
    drain();
    chk("t1_data", 64'(o_data), 64'd10000);

    // Half gain on band 3, then rounding on band 0.
    step(1'b0, 1'b1, 4'd3, 16'h2000);
    set_all(24'd0);
    i_band_data[3*DW +: DW] = -24'sd4000;
    step(1'b1);
    drain();
    chk("t2_half_gain", 64'(o_data), 64'(24'hFFF830));
    step(1'b0, 1'b1, 4'd3, 16'h4000);
    step(1'b0, 1'b1, 4'd0, 16'h2000);
    set_all(24'd0);
    i_band_data[0 +: DW] = 24'd3;
    step(1'b1);
    drain();
    chk("t2_round_pos", 64'(o_data), 64'd2);
    i_band_data[0 +: DW] = -24'sd3;
    step(1'b1);
    drain();
    chk("t2_round_neg", 64'(o_data), 64'(24'hFFFFFF));
    step(1'b0, 1'b1, 4'd0, 16'h4000);

    // Saturation both ways.
    set_all(24'h7FFFFF);
    step(1'b1);
    drain();
    chk("t3_sat_pos", 64'(o_data), 64'(24'h7FFFFF));
    set_all(24'h800000);
    step(1'b1);
    drain();
    chk("t3_sat_neg", 64'(o_data), 64'(24'h800000));

    // Overrun and gain write while busy.
    set_all(24'd1000);
    step(1'b1);
    step(1'b0);
    step(1'b0, 1'b1, 4'd0, 16'h0000);
    step(1'b0);
    step(1'b1);
    drain();
    chk("t4_current", 64'(o_data), 64'd10000);
    step(1'b1);
    drain();
    chk("t4_next", 64'(o_data), 64'd9000);
    step(1'b0, 1'b1, 4'd0, 16'h4000);

    // Reset mid-computation, with a pending non-unity gain that reset must clear.
    step(1'b0, 1'b1, 4'd2, 16'h2000);
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    step(1'b0, 1'b0, 4'd0, '0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0);
    chk("t5_no_result", 64'(q.size()), 64'd0);
    step(1'b1);
    drain();
    chk("t5_unity", 64'(o_data), 64'd10000);

    // Out-of-range gain addresses; i_en exactly in the o_valid cycle.
    step(1'b0, 1'b1, 4'd12, 16'h0000);
    step(1'b0, 1'b1, 4'd10, 16'h0000);
    step(1'b1);
    for (int i = 0; i < 12; i++) step(1'b0);
    chk("t6_valid_cycle", 64'(o_valid), 64'd1);
    set_all(24'd2000);
    step(1'b1);
    drain();
    chk("t6_back_to_back", 64'(o_data), 64'd20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
